dac7611_serial_rx: RTL and testbench
====================================

# dac7611_serial_rx

Synthesizable receiver for the DAC7611 3-wire serial load interface (CS/CLK/SDI plus LD and CLR). It oversamples the lines on the system clock, rebuilds the 12-bit word, and models the part's input and DAC registers. It sits on the loopback/verification side of the DAC driver on the ZCU102, so the driver's output pins can be checked in simulation and in hardware without the physical DAC.

## Interface
Parameters:
- SYNC_STAGES, 2: synchronizer depth on every serial input (minimum 2).
- WIDTH, 12: data word width; fixed at 12 for DAC7611, kept as a parameter for the counter and register widths.

Ports:
- clk  in  1  system clock (25 MHz nominal).
- reset  in  1  asynchronous, active-low reset.
- cs_n  in  1  chip select from the driver, active low.
- sclk  in  1  serial clock from the driver; data is valid on the rising edge.
- sdi  in  1  serial data, MSB first.
- ld_n  in  1  load strobe, active low; copies the input register to the DAC register.
- clr_n  in  1  clear, active low; forces the DAC register to 0.
- input_reg  out  WIDTH  last complete word received.
- dac_data  out  WIDTH  modelled DAC register (the value the analog output would show).
- word_ready  out  1  one-cycle pulse when input_reg updates.
- ld_pulse  out  1  one-cycle pulse when dac_data loads from input_reg.
- frame_err  out  1  one-cycle pulse on a protocol violation.
- frame_cnt  out  16  count of good frames (see Configuration).
- err_cnt  out  16  count of errors (see Configuration).

## Operation
- Inputs pass through SYNC_STAGES flops. The synchronizers reset to the idle levels: cs_n=1, ld_n=1, clr_n=1, sclk=0, sdi=0. This prevents false edges when reset is released.
- Edge detection runs on the synchronized signals: sclk rise, cs_n fall, cs_n rise, ld_n fall.
- FSM states:
  - IDLE: on a cs_n fall, go to SHIFT and clear bit_cnt.
  - SHIFT: on each sclk rise, set shift_reg = {shift_reg[WIDTH-2:0], sdi} and increment bit_cnt. When bit_cnt reaches WIDTH, go to FULL.
  - FULL: an sclk rise while cs_n is low sets an internal overrun flag; the state stays FULL.
  - On a cs_n rise from FULL with no overrun: input_reg = shift_reg, pulse word_ready, go to IDLE.
  - On a cs_n rise from SHIFT (short frame) or FULL with overrun: discard the word, pulse frame_err, go to IDLE. input_reg is unchanged.
- LD handling:
  - An ld_n fall while synced cs_n is high sets dac_data = input_reg and pulses ld_pulse.
  - An ld_n fall while cs_n is low is ignored and pulses frame_err.
- CLR handling: while synced clr_n is low, dac_data = 0 and any LD is suppressed (no ld_pulse). CLR does not affect input_reg or the FSM.
- Simultaneous events:
  - An sclk rise in the same cycle as a cs_n rise is not shifted.
  - An sclk rise in the same cycle as a cs_n fall is shifted.
  - Only one frame_err pulse is issued per cycle.

## Timing
- Reset values: input_reg=0, dac_data=0, all pulses=0, counters=0, FSM in IDLE, bit_cnt=0.
- Reset asserted mid-frame aborts the frame with no frame_err.
- Latency from a pin edge to its detected edge: SYNC_STAGES+1 clk.
- word_ready and ld_pulse assert in the same cycle their outputs update, and last exactly 1 clk.
- Input constraint: sclk high and low times each ≥ 2 clk periods. For SYNC_STAGES=2 at 25 MHz, sclk ≤ 6.25 MHz. sdi must be stable across the sclk rise plus 1 clk. Behaviour outside these limits is undefined.
- Back-to-back frames need cs_n high for ≥ 2 clk.

## Configuration
- Macro `DAC7611_RX_STATS_EN`.
- Defined: frame_cnt increments on every word_ready, and err_cnt increments on every frame_err. Both saturate at 16'hFFFF and clear only on reset.
- Undefined: the counter logic is not compiled. frame_cnt and err_cnt are tied to 0, and the ports remain.

## Test plan
- Frame 12'hCCC (MSB first, 12 sclk edges), cs_n high, then an ld_n pulse -> one word_ready pulse with input_reg=12'hCCC, then one ld_pulse with dac_data=12'hCCC.
- 8-bit short frame after a good 12'h174 frame -> one frame_err pulse; input_reg stays 12'h174; no word_ready.
- 13 sclk edges in one frame of 12'hFFF -> frame_err at the cs_n rise; input_reg unchanged; no word_ready.
- With dac_data=12'hCCC, drive clr_n low and an ld_n fall in the same window -> dac_data=0 and no ld_pulse. After clr_n returns high and ld_n pulses again, dac_data=input_reg.
- Reset asserted after 6 bits of a frame, released, then full frame 12'h174 sent -> outputs all 0 during reset, no frame_err, then input_reg=12'h174.
- With `DAC7611_RX_STATS_EN` defined: 3 good frames plus 1 short frame -> frame_cnt=3, err_cnt=1. Without the macro, both read 0.

Source files
------------

// File: rtl/dac7611_serial_rx.sv
// DAC7611 3-wire serial load receiver: oversamples CS/CLK/SDI/LD/CLR, rebuilds the word, models input and DAC registers.
// Optional frame/error statistics counters are compiled in when DAC7611_RX_STATS_EN is defined.
module dac7611_serial_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int WIDTH       = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cs_n,
    input  logic             sclk,
    input  logic             sdi,
    input  logic             ld_n,
    input  logic             clr_n,
    output logic [WIDTH-1:0] input_reg,
    output logic [WIDTH-1:0] dac_data,
    output logic             word_ready,
    output logic             ld_pulse,
    output logic             frame_err,
    output logic [15:0]      frame_cnt,
    output logic [15:0]      err_cnt
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    // Bit order of the sampled line vector: {sdi, sclk, clr_n, ld_n, cs_n}.
    localparam int B_CS   = 0;
    localparam int B_LD   = 1;
    localparam int B_CLR  = 2;
    localparam int B_SCLK = 3;
    localparam int B_SDI  = 4;
    localparam logic [4:0] IDLE_LEVELS = 5'b00111;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [SYNC_STAGES-1:0][4:0] sync_q;
    logic [4:0]                  prev_q;
    logic [4:0]                  lines_s;

    logic cs_s, clr_s, sdi_s;
    logic sclk_rise, cs_fall, cs_rise, ld_fall;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             overrun_q, overrun_d;
    logic [WIDTH-1:0] input_q, input_d;
    logic [WIDTH-1:0] dac_q, dac_d;
    logic             word_ready_q, word_ready_d;
    logic             ld_pulse_q, ld_pulse_d;
    logic             frame_err_q, frame_err_d;
    logic             shift_en;
    logic             fsm_err;
    logic             ld_err;

    // Synchronizers reset to idle line levels so releasing reset never fakes an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= IDLE_LEVELS;
            end
            prev_q <= IDLE_LEVELS;
        end else begin
            sync_q[0] <= {sdi, sclk, clr_n, ld_n, cs_n};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign lines_s   = sync_q[SYNC_STAGES-1];
    assign cs_s      = lines_s[B_CS];
    assign clr_s     = lines_s[B_CLR];
    assign sdi_s     = lines_s[B_SDI];

    assign sclk_rise =  lines_s[B_SCLK] & ~prev_q[B_SCLK];
    assign cs_fall   = ~lines_s[B_CS]   &  prev_q[B_CS];
    assign cs_rise   =  lines_s[B_CS]   & ~prev_q[B_CS];
    assign ld_fall   = ~lines_s[B_LD]   &  prev_q[B_LD];

    // Frame FSM. A cs_n rise wins over a coincident sclk rise; a cs_n fall lets it shift.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        overrun_d    = overrun_q;
        input_d      = input_q;
        word_ready_d = 1'b0;
        fsm_err      = 1'b0;
        shift_en     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = '0;
                    overrun_d = 1'b0;
                    shift_en  = sclk_rise;
                end
            end
            ST_SHIFT: begin
                if (cs_rise) begin
                    fsm_err = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    shift_en = sclk_rise;
                end
            end
            ST_FULL: begin
                if (cs_rise) begin
                    if (overrun_q) begin
                        fsm_err = 1'b1;
                    end else begin
                        input_d      = shift_q;
                        word_ready_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end else if (sclk_rise && !cs_s) begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (shift_en) begin
            shift_d   = {shift_q[WIDTH-2:0], sdi_s};
            bit_cnt_d = bit_cnt_d + 1'b1;
            if (bit_cnt_d == CNT_W'(WIDTH)) begin
                state_d = ST_FULL;
            end
        end
    end

    // Load/clear path: CLR dominates and suppresses LD; an LD inside a frame is a protocol error.
    always_comb begin
        dac_d      = dac_q;
        ld_pulse_d = 1'b0;
        ld_err     = ld_fall & ~cs_s;
        if (!clr_s) begin
            dac_d = '0;
        end else if (ld_fall && cs_s) begin
            dac_d      = input_q;
            ld_pulse_d = 1'b1;
        end
        frame_err_d = fsm_err | ld_err;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            overrun_q    <= 1'b0;
            input_q      <= '0;
            dac_q        <= '0;
            word_ready_q <= 1'b0;
            ld_pulse_q   <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            overrun_q    <= overrun_d;
            input_q      <= input_d;
            dac_q        <= dac_d;
            word_ready_q <= word_ready_d;
            ld_pulse_q   <= ld_pulse_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign input_reg  = input_q;
    assign dac_data   = dac_q;
    assign word_ready = word_ready_q;
    assign ld_pulse   = ld_pulse_q;
    assign frame_err  = frame_err_q;

`ifdef DAC7611_RX_STATS_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    // Counters track the registered pulses and stick at all-ones.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        if (word_ready_q && (frame_cnt_q != 16'hFFFF)) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
        if (frame_err_q && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;
`else
    assign frame_cnt = 16'd0;
    assign err_cnt   = 16'd0;
`endif

endmodule

// File: tb/tb_dac7611_serial_rx.sv
// Self-checking bench for dac7611_serial_rx: vector table, hand-written corner sequences and randomized frames.
module tb_dac7611_serial_rx;

    localparam int WIDTH = 12;
`ifdef DAC7611_RX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n = 1'b0;
    logic cs_n = 1'b1, sclk = 1'b0, sdi = 1'b0, ld_n = 1'b1, clr_n = 1'b1;
    logic [WIDTH-1:0] input_reg, dac_data;
    logic word_ready, ld_pulse, frame_err;
    logic [15:0] frame_cnt, err_cnt;

    dac7611_serial_rx #(.SYNC_STAGES(2), .WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset_n), .cs_n(cs_n), .sclk(sclk), .sdi(sdi),
        .ld_n(ld_n), .clr_n(clr_n), .input_reg(input_reg), .dac_data(dac_data),
        .word_ready(word_ready), .ld_pulse(ld_pulse), .frame_err(frame_err),
        .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Pulse monitor: counts pulses per transaction and captures the outputs in the pulse cycle.
    int wr_seen = 0, err_seen = 0, ld_seen = 0;
    logic [WIDTH-1:0] wr_val = '0, ld_val = '0;
    always @(negedge clk) begin
        if (reset_n) begin
            if (word_ready) begin wr_seen++; wr_val = input_reg; end
            if (ld_pulse)   begin ld_seen++; ld_val = dac_data;  end
            if (frame_err)  err_seen++;
        end
    end

    // Reference model state.
    logic [WIDTH-1:0] m_input = '0, m_dac = '0;
    int m_good = 0, m_err = 0;

    typedef struct {
        bit          do_frame;
        logic [15:0] data;
        int          nbits;
        bit          ld_mid;
        bit          do_ld;
        bit          clr;
        logic [11:0] exp_input;
        logic [11:0] exp_dac;
        int          exp_wr;
        int          exp_err;
        int          exp_ld;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_seen();
        wr_seen = 0; err_seen = 0; ld_seen = 0;
    endtask

    task automatic shift_bits(input logic [15:0] data, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            sdi = data[i];
            tick(3);
            sclk = 1'b1;
            tick(3);
            sclk = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [15:0] data, input int nbits, input bit ld_mid);
        cs_n = 1'b0;
        tick(3);
        shift_bits(data, nbits);
        if (ld_mid) begin
            tick(2); ld_n = 1'b0; tick(3); ld_n = 1'b1;
        end
        tick(3);
        cs_n = 1'b1;
        tick(6);
    endtask

    task automatic ld_strobe(input bit with_clr);
        if (with_clr) begin clr_n = 1'b0; tick(4); end
        ld_n = 1'b0; tick(4);
        ld_n = 1'b1; tick(4);
        if (with_clr) begin clr_n = 1'b1; tick(5); end
    endtask

    task automatic verify(input string tag, input logic [11:0] e_in, input logic [11:0] e_dac,
                          input int e_wr, input int e_err, input int e_ld);
        $display("txn %s: input_reg=%h dac=%h wr=%0d err=%0d ld=%0d", tag, input_reg, dac_data,
                 wr_seen, err_seen, ld_seen);
        check({tag, " input_reg"}, 32'(input_reg), 32'(e_in));
        check({tag, " dac_data"},  32'(dac_data),  32'(e_dac));
        check({tag, " word_ready pulses"}, wr_seen,  e_wr);
        check({tag, " frame_err pulses"},  err_seen, e_err);
        check({tag, " ld_pulse pulses"},   ld_seen,  e_ld);
        if (e_wr > 0 && wr_seen > 0) check({tag, " input_reg at word_ready"}, 32'(wr_val), 32'(e_in));
        if (e_ld > 0 && ld_seen > 0) check({tag, " dac_data at ld_pulse"},   32'(ld_val), 32'(e_dac));
        check({tag, " frame_cnt"}, 32'(frame_cnt), STATS ? m_good : 0);
        check({tag, " err_cnt"},   32'(err_cnt),   STATS ? m_err  : 0);
    endtask

    initial begin
        // do_frame, data, nbits, ld_mid, do_ld, clr, exp_input, exp_dac, wr, err, ld
        vecs[0] = '{1'b1, 16'h0CCC, 12, 1'b0, 1'b1, 1'b0, 12'hCCC, 12'hCCC, 1, 0, 1};
        vecs[1] = '{1'b1, 16'h0174, 12, 1'b0, 1'b0, 1'b0, 12'h174, 12'hCCC, 1, 0, 0};
        vecs[2] = '{1'b1, 16'h00A5,  8, 1'b0, 1'b0, 1'b0, 12'h174, 12'hCCC, 0, 1, 0};
        vecs[3] = '{1'b1, 16'h1FFF, 13, 1'b0, 1'b0, 1'b0, 12'h174, 12'hCCC, 0, 1, 0};
        vecs[4] = '{1'b1, 16'h0CCC, 12, 1'b0, 1'b1, 1'b1, 12'hCCC, 12'h000, 1, 0, 0};
        vecs[5] = '{1'b0, 16'h0000,  0, 1'b0, 1'b1, 1'b0, 12'hCCC, 12'hCCC, 0, 0, 1};
        vecs[6] = '{1'b1, 16'h0ABC, 12, 1'b1, 1'b0, 1'b0, 12'hABC, 12'hCCC, 1, 1, 0};
        vecs[7] = '{1'b1, 16'h0001,  1, 1'b0, 1'b0, 1'b0, 12'hABC, 12'hCCC, 0, 1, 0};
        vecs[8] = '{1'b1, 16'h0000, 12, 1'b0, 1'b1, 1'b0, 12'h000, 12'h000, 1, 0, 1};

        tick(3);
        check("reset input_reg",  32'(input_reg),  0);
        check("reset dac_data",   32'(dac_data),   0);
        check("reset word_ready", 32'(word_ready), 0);
        check("reset frame_cnt",  32'(frame_cnt),  0);
        reset_n = 1'b1;
        tick(5);

        for (int v = 0; v < 9; v++) begin
            clear_seen();
            if (vecs[v].do_frame) send_frame(vecs[v].data, vecs[v].nbits, vecs[v].ld_mid);
            if (vecs[v].do_ld) ld_strobe(vecs[v].clr);
            m_good += vecs[v].exp_wr;
            m_err  += vecs[v].exp_err;
            m_input = vecs[v].exp_input;
            m_dac   = vecs[v].exp_dac;
            verify($sformatf("vec%0d", v), vecs[v].exp_input, vecs[v].exp_dac,
                   vecs[v].exp_wr, vecs[v].exp_err, vecs[v].exp_ld);
        end

        // sclk rise coincident with cs_n fall is shifted as the first bit.
        clear_seen();
        sdi = 1'b1; cs_n = 1'b0; sclk = 1'b1;
        tick(3); sclk = 1'b0;
        shift_bits(16'h09A5, 11);
        tick(3); cs_n = 1'b1; tick(6);
        m_input = 12'h9A5; m_good++;
        verify("cs_fall+sclk", m_input, m_dac, 1, 0, 0);

        // sclk rise coincident with cs_n rise after a full word is not shifted: no overrun.
        clear_seen();
        cs_n = 1'b0; tick(3);
        shift_bits(16'h0E1D, 12);
        tick(3); cs_n = 1'b1; sclk = 1'b1;
        tick(3); sclk = 1'b0; tick(6);
        m_input = 12'hE1D; m_good++;
        verify("cs_rise+sclk", m_input, m_dac, 1, 0, 0);

        // Reset in the middle of a frame aborts it silently.
        cs_n = 1'b0; tick(3);
        shift_bits(16'h003F, 6);
        reset_n = 1'b0;
        tick(2);
        check("midreset input_reg",  32'(input_reg),  0);
        check("midreset dac_data",   32'(dac_data),   0);
        check("midreset pulses",     32'({word_ready, ld_pulse, frame_err}), 0);
        check("midreset frame_cnt",  32'(frame_cnt),  0);
        check("midreset err_cnt",    32'(err_cnt),    0);
        cs_n = 1'b1; sclk = 1'b0;
        tick(3);
        m_input = '0; m_dac = '0; m_good = 0; m_err = 0;
        clear_seen();
        reset_n = 1'b1;
        tick(6);
        send_frame(16'h0174, 12, 1'b0);
        m_input = 12'h174; m_good++;
        verify("after-reset", m_input, m_dac, 1, 0, 0);

        // Randomized frames against the reference rules.
        for (int r = 0; r < 30; r++) begin
            logic [15:0] data;
            int nbits, kind, e_ld;
            bit do_ld, clr;
            data  = 16'($urandom);
            kind  = $urandom_range(0, 3);
            nbits = (kind == 0) ? $urandom_range(1, 11) : (kind == 3) ? $urandom_range(13, 14) : 12;
            do_ld = 1'($urandom_range(0, 1));
            clr   = ($urandom_range(0, 3) == 0);
            clear_seen();
            send_frame(data, nbits, 1'b0);
            if (do_ld) ld_strobe(clr);
            if (nbits == WIDTH) begin m_input = data[11:0]; m_good++; end
            else m_err++;
            e_ld = 0;
            if (do_ld) begin
                if (clr) m_dac = '0;
                else begin m_dac = m_input; e_ld = 1; end
            end
            verify($sformatf("rnd%0d n=%0d", r, nbits), m_input, m_dac,
                   (nbits == WIDTH) ? 1 : 0, (nbits == WIDTH) ? 0 : 1, e_ld);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
